image_scheduler: RTL and testbench

IMAGE_SCHEDULER -- requirements
Module: image_scheduler

---
 rtl/image_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_image_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_scheduler.sv
// image_scheduler
// Sequences a batch of images from an image store into the classifier
// datapath. For every image the scheduler pulses start_main, fetches
// IMG_WORDS pixel words one at a time and forwards each to the datapath. It
// then waits for the datapath decision and records the result. When the
// batch completes it pulses done.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   run, abort          : batch start pulse (IDLE only), synchronous abort
//   mode, num_images    : batch mode (00 train, 01 test, 10 classify) and size
//   rd_req, img_addr,
//   word_idx            : word fetch request towards the image store
//   rd_valid, rd_data,
//   label_in            : fetched word and dataset label (label with word 0)
//   start_main, ttc,
//   test_label,
//   image_out,
//   valid_image         : per-image start, latched mode, label and word stream
//   dp_ready, valid_all,
//   image_label         : datapath flow control and decision
//   busy, done, err     : batch active, batch-end pulse, sticky timeout flag
//   result_valid,
//   result_label        : per-image decision pulse and value
//   img_count,
//   correct_count       : completed images and correct test decisions

module image_scheduler #(
    parameter int IMG_WORDS = 196,
    parameter int TIMEOUT   = 1048575
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        abort,
    input  logic [1:0]  mode,
    input  logic [15:0] num_images,
    output logic        rd_req,
    output logic [15:0] img_addr,
    output logic [7:0]  word_idx,
    input  logic        rd_valid,
    input  logic [31:0] rd_data,
    input  logic [7:0]  label_in,
    output logic        start_main,
    output logic [1:0]  ttc,
    output logic [7:0]  test_label,
    output logic [31:0] image_out,
    output logic        valid_image,
    input  logic        dp_ready,
    input  logic        valid_all,
    input  logic [7:0]  image_label,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        result_valid,
    output logic [7:0]  result_label,
    output logic [15:0] img_count,
    output logic [15:0] correct_count
);

    localparam logic [7:0]  LAST_WORD = 8'(IMG_WORDS - 1);
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT);
    localparam logic [1:0]  MODE_TEST = 2'b01;
    localparam logic [1:0]  MODE_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_LOAD   = 3'd2,
        S_WAIT   = 3'd3,
        S_RECORD = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      state;
    logic        pending;      // one word requested and not yet returned
    logic [15:0] num_r;        // batch size latched at run
    logic [31:0] tmo_cnt;      // cycles spent in WAIT for the current image

    // Saturating 16-bit increment: counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        logic [15:0] res;
        if (val == 16'hFFFF) begin
            res = val;
        end else begin
            res = val + 16'd1;
        end
        return res;
    endfunction

    // Fetch request: qualified by the live dp_ready so a request never issues while
    // the datapath is stalled, and never while a word is still outstanding.
    assign rd_req = (state == S_LOAD) && !pending && dp_ready && !abort;

    // Batch sequencer: state, fetch bookkeeping, registered outputs and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            pending       <= 1'b0;
            num_r         <= 16'd0;
            tmo_cnt       <= 32'd0;
            img_addr      <= 16'd0;
            word_idx      <= 8'd0;
            start_main    <= 1'b0;
            ttc           <= 2'b00;
            test_label    <= 8'd0;
            image_out     <= 32'd0;
            valid_image   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            result_valid  <= 1'b0;
            result_label  <= 8'd0;
            img_count     <= 16'd0;
            correct_count <= 16'd0;
        end else begin
            // Pulse outputs fall by default; transitions below raise them for one cycle.
            start_main   <= 1'b0;
            valid_image  <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;

            if (abort && (state != S_IDLE)) begin
                // Abort wins over everything else; counters are held and any word
                // still in flight is dropped because IDLE ignores rd_valid.
                state   <= S_IDLE;
                busy    <= 1'b0;
                pending <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (run && (mode != MODE_RSVD)) begin
                            img_count     <= 16'd0;
                            correct_count <= 16'd0;
                            busy          <= 1'b1;
                            if (num_images == 16'd0) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                ttc        <= mode;
                                num_r      <= num_images;
                                err        <= 1'b0;
                                img_addr   <= 16'd0;
                                word_idx   <= 8'd0;
                                pending    <= 1'b0;
                                start_main <= 1'b1;
                                state      <= S_START;
                            end
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_START: begin
                        word_idx <= 8'd0;
                        pending  <= 1'b0;
                        state    <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (rd_req) begin
                            pending <= 1'b1;
                        end else if (pending && rd_valid) begin
                            image_out   <= rd_data;
                            valid_image <= 1'b1;
                            pending     <= 1'b0;
                            word_idx    <= word_idx + 8'd1;
                            if (word_idx == 8'd0) begin
                                test_label <= label_in;
                            end else begin
                                test_label <= test_label;
                            end
                            if (word_idx == LAST_WORD) begin
                                tmo_cnt <= 32'd0;
                                state   <= S_WAIT;
                            end else begin
                                state <= S_LOAD;
                            end
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                    S_WAIT: begin
                        if (valid_all) begin
                            result_label <= image_label;
                            result_valid <= 1'b1;
                            img_count    <= sat_inc(img_count);
                            if ((ttc == MODE_TEST) && (image_label == test_label)) begin
                                correct_count <= sat_inc(correct_count);
                            end else begin
                                correct_count <= correct_count;
                            end
                            state <= S_RECORD;
                        end else if ((tmo_cnt + 32'd1) == TMO_LIMIT) begin
                            // The counter has now seen TIMEOUT WAIT cycles.
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 32'd1;
                        end
                    end
                    S_RECORD: begin
                        // img_count already holds the incremented value here.
                        if (img_count == num_r) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            img_addr   <= img_addr + 16'd1;
                            word_idx   <= 8'd0;
                            start_main <= 1'b1;
                            state      <= S_START;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy    <= 1'b0;
                        pending <= 1'b0;
                        state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_image_scheduler.sv
// Directed bench for image_scheduler: a small image-store responder, a
// negedge monitor that checks the forwarded word stream, and directed batches.
module tb_image_scheduler;

    localparam int IMG_WORDS = 196;
    localparam int TIMEOUT   = 100;

    logic        clk;
    logic        rst;
    logic        run;
    logic        abort;
    logic [1:0]  mode;
    logic [15:0] num_images;
    logic        rd_req;
    logic [15:0] img_addr;
    logic [7:0]  word_idx;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [7:0]  label_in;
    logic        start_main;
    logic [1:0]  ttc;
    logic [7:0]  test_label;
    logic [31:0] image_out;
    logic        valid_image;
    logic        dp_ready;
    logic        valid_all;
    logic [7:0]  image_label;
    logic        busy;
    logic        done;
    logic        err;
    logic        result_valid;
    logic [7:0]  result_label;
    logic [15:0] img_count;
    logic [15:0] correct_count;

    image_scheduler #(.IMG_WORDS(IMG_WORDS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .run(run), .abort(abort), .mode(mode),
        .num_images(num_images), .rd_req(rd_req), .img_addr(img_addr),
        .word_idx(word_idx), .rd_valid(rd_valid), .rd_data(rd_data),
        .label_in(label_in), .start_main(start_main), .ttc(ttc),
        .test_label(test_label), .image_out(image_out), .valid_image(valid_image),
        .dp_ready(dp_ready), .valid_all(valid_all), .image_label(image_label),
        .busy(busy), .done(done), .err(err), .result_valid(result_valid),
        .result_label(result_label), .img_count(img_count),
        .correct_count(correct_count)
    );

    int checks   = 0;
    int failures = 0;

    int mem_lat   = 1;
    bit dp_toggle = 1'b0;

    // Monitor state
    int cyc = 0, starts = 0, words = 0, total_words = 0, data_err = 0;
    int req_viol = 0, dones = 0, done_cyc = 0, last_vi_cyc = 0, res_n = 0;
    logic [7:0] res_log [0:15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image store contents: a word is a function of image index and word index.
    function automatic logic [31:0] pix(input logic [15:0] a, input logic [7:0] w);
        return {a[7:0] ^ 8'h5A, w, ~w, 8'hC3};
    endfunction

    function automatic logic [7:0] label_of(input logic [15:0] a);
        return a[0] ? 8'd7 : 8'd3;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for image number s_target (counted by start_main pulses) to reach n words.
    task automatic wait_words(input int s_target, input int n, input string tag);
        int k;
        k = 0;
        while (!(starts >= s_target && words >= n) && k < 5000) begin
            if (dp_toggle) dp_ready = ~dp_ready;
            tick();
            k++;
        end
        dp_ready = 1'b1;
        check_eq(tag, 32'(starts >= s_target && words >= n), 32'd1);
    endtask

    task automatic wait_done(input int d_target, input string tag);
        int k;
        k = 0;
        while (dones < d_target && k < 1000) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(dones >= d_target), 32'd1);
    endtask

    task automatic serve_image(input int s_target, input logic [7:0] lbl, input string tag);
        wait_words(s_target, IMG_WORDS, tag);
        tick();
        valid_all   = 1'b1;
        image_label = lbl;
        tick();
        valid_all   = 1'b0;
    endtask

    // Image store: answers each request after mem_lat cycles.
    initial begin : mem_model
        logic [15:0] a;
        logic [7:0]  w;
        rd_valid = 1'b0;
        rd_data  = 32'd0;
        label_in = 8'd0;
        forever begin
            @(negedge clk);
            if (rd_req === 1'b1) begin
                a = img_addr;
                w = word_idx;
                repeat (mem_lat) @(posedge clk);
                #1;
                rd_valid = 1'b1;
                rd_data  = pix(a, w);
                label_in = label_of(a);
                @(posedge clk);
                #1;
                rd_valid = 1'b0;
            end
        end
    end

    // Monitor: counts pulses and checks forwarded words arrive in order.
    always @(negedge clk) begin
        cyc++;
        if (start_main) begin
            starts++;
            words = 0;
        end
        if (valid_image) begin
            if (image_out !== pix(img_addr, 8'(words))) data_err++;
            words++;
            total_words++;
            last_vi_cyc = cyc;
        end
        if (rd_req && !dp_ready) req_viol++;
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
        if (result_valid && res_n < 16) begin
            res_log[res_n] = result_label;
            res_n++;
        end
    end

    initial begin : main
        int s0, d0, r0, t0, e0, v0, n;
        rst = 1'b0; run = 1'b0; abort = 1'b0; mode = 2'b00; num_images = 16'd0;
        dp_ready = 1'b1; valid_all = 1'b0; image_label = 8'd0;

        // Reset state
        repeat (2) tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_ttc", 32'(ttc), 32'd0);
        check_eq("rst_img_count", 32'(img_count), 32'd0);
        check_eq("rst_rd_req", 32'(rd_req), 32'd0);

        // Two-image test batch; run presented with reset release
        s0 = starts; d0 = dones; r0 = res_n; t0 = total_words; e0 = data_err;
        rst = 1'b1; run = 1'b1; mode = 2'b01; num_images = 16'd2;
        tick();
        run = 1'b0;
        check_eq("b1_first_run_busy", 32'(busy), 32'd1);
        check_eq("b1_start_main", 32'(start_main), 32'd1);
        check_eq("b1_ttc", 32'(ttc), 32'd1);
        repeat (3) tick();
        run = 1'b1; mode = 2'b00; num_images = 16'd0;   // ignored while busy
        tick();
        run = 1'b0;
        serve_image(s0 + 1, 8'd3, "b1_img0_words");
        serve_image(s0 + 2, 8'd5, "b1_img1_words");
        wait_done(d0 + 1, "b1_done_seen");
        tick();
        check_eq("b1_done_pulses", 32'(dones - d0), 32'd1);
        check_eq("b1_starts", 32'(starts - s0), 32'd2);
        check_eq("b1_words", 32'(total_words - t0), 32'd392);
        check_eq("b1_data_err", 32'(data_err - e0), 32'd0);
        check_eq("b1_results", 32'(res_n - r0), 32'd2);
        check_eq("b1_res0", 32'(res_log[r0]), 32'd3);
        check_eq("b1_res1", 32'(res_log[r0 + 1]), 32'd5);
        check_eq("b1_img_count", 32'(img_count), 32'd2);
        check_eq("b1_correct", 32'(correct_count), 32'd1);
        check_eq("b1_ttc_held", 32'(ttc), 32'd1);
        check_eq("b1_test_label", 32'(test_label), 32'd7);
        check_eq("b1_err", 32'(err), 32'd0);
        check_eq("b1_busy_end", 32'(busy), 32'd0);

        // Zero-image batch
        s0 = starts; d0 = dones;
        run = 1'b1; mode = 2'b00; num_images = 16'd0;
        tick();
        run = 1'b0;
        n = 1;
        while (!done && n < 5) begin
            tick();
            n++;
        end
        check_eq("nz_done_within_2", 32'(n >= 1 && n <= 2), 32'd1);
        tick();
        check_eq("nz_no_start", 32'(starts - s0), 32'd0);
        check_eq("nz_img_count", 32'(img_count), 32'd0);
        check_eq("nz_correct", 32'(correct_count), 32'd0);

        // Reserved mode is ignored
        run = 1'b1; mode = 2'b11; num_images = 16'd1;
        tick();
        run = 1'b0;
        check_eq("rsvd_ignored", 32'(busy), 32'd0);

        // dp_ready toggling, 2-cycle store latency, train mode
        s0 = starts; t0 = total_words; e0 = data_err; v0 = req_viol; d0 = dones;
        mem_lat = 2; dp_toggle = 1'b1;
        run = 1'b1; mode = 2'b00; num_images = 16'd1;
        tick();
        run = 1'b0;
        serve_image(s0 + 1, 8'd3, "dp_words");
        dp_toggle = 1'b0; mem_lat = 1;
        wait_done(d0 + 1, "dp_done_seen");
        check_eq("dp_req_while_low", 32'(req_viol - v0), 32'd0);
        check_eq("dp_word_count", 32'(total_words - t0), 32'd196);
        check_eq("dp_data_err", 32'(data_err - e0), 32'd0);
        check_eq("dp_img_count", 32'(img_count), 32'd1);
        check_eq("dp_train_no_correct", 32'(correct_count), 32'd0);

        // Timeout: valid_all never arrives
        s0 = starts; d0 = dones; r0 = res_n;
        run = 1'b1; mode = 2'b10; num_images = 16'd1;
        tick();
        run = 1'b0;
        wait_words(s0 + 1, IMG_WORDS, "tmo_words");
        wait_done(d0 + 1, "tmo_done_seen");
        check_eq("tmo_wait_cycles", 32'(done_cyc - last_vi_cyc), 32'(TIMEOUT));
        check_eq("tmo_err", 32'(err), 32'd1);
        check_eq("tmo_img_count", 32'(img_count), 32'd0);
        check_eq("tmo_no_result", 32'(res_n - r0), 32'd0);

        // Abort at word 50 of the second image
        s0 = starts;
        run = 1'b1; mode = 2'b01; num_images = 16'd2;
        tick();
        run = 1'b0;
        check_eq("ab_err_cleared", 32'(err), 32'd0);
        serve_image(s0 + 1, 8'd3, "ab_img0_words");
        wait_words(s0 + 2, 50, "ab_img1_words");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("ab_busy", 32'(busy), 32'd0);
        t0 = total_words; d0 = dones;
        repeat (10) tick();
        check_eq("ab_no_more_words", 32'(total_words - t0), 32'd0);
        check_eq("ab_no_done", 32'(dones - d0), 32'd0);
        check_eq("ab_img_count_held", 32'(img_count), 32'd1);
        check_eq("ab_correct_held", 32'(correct_count), 32'd1);
        check_eq("ab_img_addr_held", 32'(img_addr), 32'd1);
        s0 = starts; d0 = dones;
        run = 1'b1; mode = 2'b01; num_images = 16'd1;
        tick();
        run = 1'b0;
        check_eq("ab_restart_addr", 32'(img_addr), 32'd0);
        check_eq("ab_restart_count", 32'(img_count), 32'd0);
        serve_image(s0 + 1, 8'd3, "ab_rerun_words");
        wait_done(d0 + 1, "ab_rerun_done");
        check_eq("ab_rerun_correct", 32'(correct_count), 32'd1);

        // Reset in WAIT with run and valid_all in the same cycle
        s0 = starts;
        run = 1'b1; mode = 2'b01; num_images = 16'd1;
        tick();
        run = 1'b0;
        wait_words(s0 + 1, IMG_WORDS, "rw_words");
        tick();
        rst = 1'b0; run = 1'b1; valid_all = 1'b1; image_label = 8'd3;
        #1;
        check_eq("rw_busy", 32'(busy), 32'd0);
        check_eq("rw_counts", {img_count, correct_count}, 32'd0);
        check_eq("rw_labels", {8'd0, test_label, result_label, 6'd0, ttc}, 32'd0);
        check_eq("rw_image_out", image_out, 32'd0);
        check_eq("rw_addr", {8'd0, word_idx, img_addr}, 32'd0);
        check_eq("rw_pulses", 32'({start_main, valid_image, done, err, result_valid, rd_req}), 32'd0);
        tick();
        check_eq("rw_held_busy", 32'(busy), 32'd0);
        rst = 1'b1; run = 1'b0; valid_all = 1'b0;
        tick();
        check_eq("rw_after_busy", 32'(busy), 32'd0);
        check_eq("rw_after_result", 32'(result_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
